// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end for the 10-bit teaching
//               processor. Drives the instruction ROM address from the PC.
//               Captures the combinational ROM read data into a one-entry
//               output slot, which it hands to decode over valid/ready.
//               Accepts branch/jump redirects from execute. Stops fetching
//               once the halt word has been fetched.
// Ports       : clk, rst_n (async, active-low)
//               rom_address   -> ROM read address (= pc)
//               rom_read_data <- ROM word at rom_address (combinational)
//               instr_valid/instr_ready/instr_data/instr_pc -> decode
//               redirect_valid/redirect_pc <- execute
//               halted        -> fetch stopped after the halt word
//               perf_fetch_count/perf_stall_count (FETCH_PERF_EN only)
// Options     : define FETCH_PERF_EN to add two saturating 16-bit counters,
//               one for transfers and one for stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W    = 10,
  parameter int unsigned        INSTR_W   = 10,
  parameter int unsigned        RESET_PC  = 1,
  parameter logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_read_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_fetch_count,
  output logic [15:0]        perf_stall_count,
`endif
  output logic               halted
);

  localparam logic [ADDR_W-1:0] RESET_PC_VAL = ADDR_W'(RESET_PC);

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;

  logic slot_free;
  logic xfer;

  assign slot_free = !valid_q || instr_ready;
  assign xfer      = valid_q && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    if (redirect_valid) begin
      // Redirect flushes the slot; any same-edge transfer has already
      // been delivered to decode, so nothing is replayed.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (slot_free) begin
            data_d  = rom_read_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            if (rom_read_data == HALT_WORD) begin
              state_d = HALTED;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
        HALTED: begin
          // Halt word lingers until decode takes it, then the slot empties.
          if (xfer) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_VAL;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  assign rom_address = pc_q;
  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (xfer && (perf_fetch_q != 16'hFFFF)) begin
      perf_fetch_d = perf_fetch_q + 16'd1;
    end
    if (valid_q && !instr_ready && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 16'd0;
      perf_stall_q <= 16'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_count = perf_fetch_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
`default_nettype wire
